sprite_path_mover: RTL and testbench



---
 rtl/sprite_pkg.sv | 65 ++++++
 rtl/sprite_seg_table.sv | 67 ++++++
 rtl/sprite_path_mover.sv | 122 ++++++++++++
 tb/tb_sprite_path_mover.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite path mover: direction and state
// encodings, walkway segment field layout, and the candidate step function.
package sprite_pkg;

    typedef enum logic [1:0] {
        DIR_PXPY = 2'd0,
        DIR_NXPY = 2'd1,
        DIR_PXNY = 2'd2,
        DIR_NXNY = 2'd3
    } dir_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LATCH,
        S_CHECK,
        S_ERASE,
        S_WAIT_BG,
        S_UPDATE,
        S_DRAW,
        S_WAIT_CHAR,
        S_BLOCKED
    } state_e;

    typedef struct packed {
        int x;
        int y;
    } pos_t;

    // Segment word layout, LSB first: xmax, xmin, c (signed, xw+1 bits), neg, en.
    function automatic int seg_width(int xw);
        return 3 * xw + 3;
    endfunction

    function automatic int seg_xmax_lsb(int xw);
        return 0 * xw;
    endfunction

    function automatic int seg_xmin_lsb(int xw);
        return xw;
    endfunction

    function automatic int seg_c_lsb(int xw);
        return 2 * xw;
    endfunction

    function automatic int seg_neg_bit(int xw);
        return 3 * xw + 1;
    endfunction

    function automatic int seg_en_bit(int xw);
        return 3 * xw + 2;
    endfunction

    function automatic int seg_idx_width(int num_seg);
        return (num_seg > 1) ? $clog2(num_seg) : 1;
    endfunction

    function automatic pos_t next_pos(dir_e dir, int x, int y, int step);
        pos_t p;
        p.x = (dir == DIR_NXPY || dir == DIR_NXNY) ? x - step : x + step;
        p.y = (dir == DIR_PXNY || dir == DIR_NXNY) ? y - step : y + step;
        return p;
    endfunction

endpackage

// File: rtl/sprite_seg_table.sv
// Runtime-loadable table of diagonal walkway segments with a combinational
// match of one selected entry against a candidate position.
module sprite_seg_table
    import sprite_pkg::*;
#(
    parameter int X_W     = 9,
    parameter int Y_W     = 8,
    parameter int NUM_SEG = 4,
    parameter int IDX_W   = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        we,
    input  logic [IDX_W-1:0]            widx,
    input  logic [seg_width(X_W)-1:0]   wdata,
    input  logic [IDX_W-1:0]            ridx,
    input  logic signed [X_W:0]         cand_x,
    input  logic signed [Y_W:0]         cand_y,
    output logic                        match
);

    localparam int SEG_W  = seg_width(X_W);
    localparam int EN_BIT = seg_en_bit(X_W);

    logic [NUM_SEG-1:0] en_q;
    logic [SEG_W-2:0]   body_q [NUM_SEG];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            en_q <= '0;
        end else if (we) begin
            en_q[widx] <= wdata[EN_BIT];
        end
    end

    // NOTE: entry bodies are deliberately not reset; a cleared en bit keeps them from ever matching.
    always_ff @(posedge clock) begin
        if (we) begin
            body_q[widx] <= wdata[SEG_W-2:0];
        end
    end

    logic [SEG_W-2:0]       ent;
    logic                   ent_neg;
    logic [X_W-1:0]         ent_xmin, ent_xmax, x_u;
    logic signed [X_W+1:0]  ex, ey, cx, rhs;
    logic                   in_range, on_seg;

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        ent      = body_q[ridx];
        ent_neg  = ent[seg_neg_bit(X_W)];
        ent_xmin = ent[seg_xmin_lsb(X_W) +: X_W];
        ent_xmax = ent[seg_xmax_lsb(X_W) +: X_W];
        cx       = (X_W+2)'($signed(ent[seg_c_lsb(X_W) +: X_W+1]));
        ex       = (X_W+2)'(cand_x);
        ey       = (X_W+2)'(cand_y);
        x_u      = cand_x[X_W-1:0];
        rhs      = ent_neg ? (cx - ex) : (ex + cx);
        // A positive, non-zero signed candidate is exactly the 1..2^W-1 range.
        in_range = !cand_x[X_W] && (cand_x != '0) && !cand_y[Y_W] && (cand_y != '0);
        on_seg   = (ey == rhs);
        match    = en_q[ridx] && in_range && (x_u >= ent_xmin) && (x_u <= ent_xmax) && on_seg;
    end

endmodule

// File: rtl/sprite_path_mover.sv
// Sprite movement controller: validates each step against the walkway table
// and sequences background-erase / character-draw handshakes per step.
module sprite_path_mover
    import sprite_pkg::*;
#(
    parameter int X_W     = 9,
    parameter int Y_W     = 8,
    parameter int NUM_SEG = 4,
    parameter int STEP    = 1,
    parameter int INIT_X  = 1,
    parameter int INIT_Y  = 16
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                move,
    input  logic [1:0]                          dir,
    input  logic [3:0]                          steps,
    input  logic                                seg_we,
    input  logic [seg_idx_width(NUM_SEG)-1:0]   seg_idx,
    input  logic [seg_width(X_W)-1:0]           seg_data,
    input  logic                                doneBG,
    input  logic                                doneChar,
    output logic                                drawBG,
    output logic                                drawChar,
    output logic [X_W-1:0]                      xCoordinate,
    output logic [Y_W-1:0]                      yCoordinate,
    output logic                                busy,
    output logic                                blocked
);

    localparam int               IDX_W    = seg_idx_width(NUM_SEG);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SEG - 1);

    state_e               state_q, state_d;
    dir_e                 dir_q;
    logic [3:0]           rem_q;
    logic [IDX_W-1:0]     idx_q;
    logic signed [X_W:0]  new_x;
    logic signed [Y_W:0]  new_y;
    logic                 seg_match;
    pos_t                 cand;

    sprite_seg_table #(
        .X_W     (X_W),
        .Y_W     (Y_W),
        .NUM_SEG (NUM_SEG),
        .IDX_W   (IDX_W)
    ) u_table (
        .clock  (clock),
        .reset  (reset),
        .we     (seg_we && (state_q == S_IDLE)),
        .widx   (seg_idx),
        .wdata  (seg_data),
        .ridx   (idx_q),
        .cand_x (new_x),
        .cand_y (new_y),
        .match  (seg_match)
    );

    always_comb cand = next_pos(dir_q, int'(xCoordinate), int'(yCoordinate), STEP);

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (move) state_d = S_LATCH;
            S_LATCH:     state_d = S_CHECK;
            S_CHECK: begin
                if (seg_match)              state_d = S_ERASE;
                else if (idx_q == IDX_LAST) state_d = S_BLOCKED;
            end
            S_ERASE:     state_d = S_WAIT_BG;
            S_WAIT_BG:   if (doneBG) state_d = S_UPDATE;
            S_UPDATE:    state_d = S_DRAW;
            S_DRAW:      state_d = S_WAIT_CHAR;
            S_WAIT_CHAR: if (doneChar) state_d = (rem_q != '0) ? S_LATCH : S_IDLE;
            S_BLOCKED:   state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            xCoordinate <= X_W'(INIT_X);
            yCoordinate <= Y_W'(INIT_Y);
            dir_q       <= DIR_PXPY;
            rem_q       <= '0;
            idx_q       <= '0;
            new_x       <= '0;
            new_y       <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (move) begin
                    dir_q <= dir_e'(dir);
                    rem_q <= (steps == '0) ? 4'd1 : steps;
                end
                S_LATCH: begin
                    new_x <= (X_W+1)'(cand.x);
                    new_y <= (Y_W+1)'(cand.y);
                    idx_q <= '0;
                end
                S_CHECK: if (!seg_match && idx_q != IDX_LAST) idx_q <= idx_q + 1'b1;
                S_UPDATE: begin
                    xCoordinate <= new_x[X_W-1:0];
                    yCoordinate <= new_y[Y_W-1:0];
                    rem_q       <= rem_q - 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign drawBG   = (state_q == S_ERASE);
    assign drawChar = (state_q == S_DRAW);
    assign busy     = (state_q != S_IDLE);
    assign blocked  = (state_q == S_BLOCKED);

endmodule

// File: tb/tb_sprite_path_mover.sv
// Directed self-checking bench for sprite_path_mover: handshake timing,
// walkway validation, multi-step moves, reset and protocol corner cases.
module tb_sprite_path_mover;

    logic        clock = 1'b0;
    logic        reset, move, seg_we, doneBG, doneChar;
    logic [1:0]  dir, seg_idx;
    logic [3:0]  steps;
    logic [29:0] seg_data;
    logic        drawBG, drawChar, busy, blocked;
    logic [8:0]  xCoordinate;
    logic [7:0]  yCoordinate;

    int checks = 0;
    int errors = 0;
    int n_bg, n_char, n_blk, bg_cyc, ch_cyc, blk_cyc, end_cyc;
    int mx, my;

    always #5 clock = ~clock;

    sprite_path_mover dut (
        .clock       (clock),
        .reset       (reset),
        .move        (move),
        .dir         (dir),
        .steps       (steps),
        .seg_we      (seg_we),
        .seg_idx     (seg_idx),
        .seg_data    (seg_data),
        .doneBG      (doneBG),
        .doneChar    (doneChar),
        .drawBG      (drawBG),
        .drawChar    (drawChar),
        .xCoordinate (xCoordinate),
        .yCoordinate (yCoordinate),
        .busy        (busy),
        .blocked     (blocked)
    );

    function automatic logic [29:0] mk_seg(bit en, bit neg, int c, int xmin, int xmax);
        logic [9:0] cv;
        logic [8:0] lo, hi;
        cv = 10'(c);
        lo = 9'(xmin);
        hi = 9'(xmax);
        return {en, neg, cv, lo, hi};
    endfunction

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic write_seg(input int idx, input logic [29:0] d);
        @(negedge clock);
        seg_we   = 1'b1;
        seg_idx  = 2'(idx);
        seg_data = d;
        @(negedge clock);
        seg_we   = 1'b0;
    endtask

    // Issues one move and services handshakes; cycle 1 is the cycle after move is sampled.
    task automatic do_move(input logic [1:0] d, input logic [3:0] s, input bit hold, input bit poke);
        bit bg_pend = 0, ch_pend = 0, hbg = 0, hch = 0;
        int cyc;
        n_bg = 0; n_char = 0; n_blk = 0;
        bg_cyc = -1; ch_cyc = -1; blk_cyc = -1;
        @(negedge clock);
        dir = d; steps = s; move = 1'b1;
        @(negedge clock);
        move = 1'b0;
        cyc = 1;
        forever begin
            if (drawBG)   begin n_bg++;   if (bg_cyc < 0)  bg_cyc = cyc;  end
            if (drawChar) begin n_char++; if (ch_cyc < 0)  ch_cyc = cyc;  end
            if (blocked)  begin n_blk++;  if (blk_cyc < 0) blk_cyc = cyc; end
            if (!busy) break;
            if (cyc >= 400) begin
                checks++; errors++;
                $display("FAIL move_timeout: busy still high after %0d cycles, required low", cyc);
                break;
            end
            if (poke) begin
                if (cyc == 2) begin
                    move = 1'b1; dir = ~d; steps = 4'd15;
                    seg_we = 1'b1; seg_idx = 2'd0; seg_data = mk_seg(0, 0, 0, 0, 0);
                end else begin
                    move = 1'b0; seg_we = 1'b0;
                end
            end
            if (hold) begin
                if (drawBG) hbg = 1;
                if (drawChar) begin hbg = 0; hch = 1; end
                doneBG = hbg; doneChar = hch;
            end else begin
                doneBG = bg_pend; doneChar = ch_pend;
                bg_pend = drawBG; ch_pend = drawChar;
            end
            @(negedge clock);
            cyc++;
        end
        end_cyc = cyc;
        doneBG = 1'b0; doneChar = 1'b0; move = 1'b0; seg_we = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({xCoordinate, yCoordinate} !== {9'd1, 8'd16}) begin
            errors++;
            $display("FAIL reset_pos: got (%0d,%0d), expected (1,16)", xCoordinate, yCoordinate);
        end
        checks++;
        if ({drawBG, drawChar, busy, blocked} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected 0000", {drawBG, drawChar, busy, blocked});
        end
        do_move(2'd0, 4'd1, 0, 0);
        checks++;
        if (blk_cyc !== 6 || n_bg !== 0) begin
            errors++;
            $display("FAIL reset_table_empty: blocked cycle %0d drawBG count %0d, expected 6 and 0", blk_cyc, n_bg);
        end
    endtask

    task automatic test_single_step();
        write_seg(0, mk_seg(1, 0, 15, 1, 161));
        do_move(2'd0, 4'd1, 0, 0);
        checks++;
        if (bg_cyc !== 3 || n_bg !== 1) begin
            errors++;
            $display("FAIL single_drawbg: cycle %0d count %0d, expected 3 and 1", bg_cyc, n_bg);
        end
        checks++;
        if (ch_cyc !== 6 || n_char !== 1) begin
            errors++;
            $display("FAIL single_drawchar: cycle %0d count %0d, expected 6 and 1", ch_cyc, n_char);
        end
        checks++;
        if ({xCoordinate, yCoordinate} !== {9'd2, 8'd17}) begin
            errors++;
            $display("FAIL single_pos: got (%0d,%0d), expected (2,17)", xCoordinate, yCoordinate);
        end
        checks++;
        if (end_cyc !== 8) begin
            errors++;
            $display("FAIL single_busy_drop: idle in cycle %0d, expected 8", end_cyc);
        end
    endtask

    task automatic test_underflow();
        apply_reset();
        write_seg(0, mk_seg(1, 0, 15, 1, 161));
        do_move(2'd3, 4'd1, 0, 0);
        checks++;
        if (blk_cyc !== 6 || n_blk !== 1 || n_bg !== 0) begin
            errors++;
            $display("FAIL underflow_blocked: cycle %0d pulses %0d drawBG %0d, expected 6,1,0", blk_cyc, n_blk, n_bg);
        end
        checks++;
        if ({xCoordinate, yCoordinate} !== {9'd1, 8'd16}) begin
            errors++;
            $display("FAIL underflow_pos: got (%0d,%0d), expected (1,16)", xCoordinate, yCoordinate);
        end
    endtask

    task automatic test_multi_step();
        do_move(2'd0, 4'd3, 0, 0);
        checks++;
        if (n_bg !== 3 || n_char !== 3) begin
            errors++;
            $display("FAIL multi_pairs: drawBG %0d drawChar %0d, expected 3 and 3", n_bg, n_char);
        end
        checks++;
        if ({xCoordinate, yCoordinate} !== {9'd4, 8'd19} || busy !== 1'b0) begin
            errors++;
            $display("FAIL multi_final: got (%0d,%0d) busy %b, expected (4,19) busy 0", xCoordinate, yCoordinate, busy);
        end
        checks++;
        if (end_cyc !== 22) begin
            errors++;
            $display("FAIL multi_timing: idle in cycle %0d, expected 22", end_cyc);
        end
        do_move(2'd0, 4'd0, 0, 0);
        checks++;
        if (n_bg !== 1 || {xCoordinate, yCoordinate} !== {9'd5, 8'd20}) begin
            errors++;
            $display("FAIL steps_zero: drawBG %0d pos (%0d,%0d), expected 1 and (5,20)", n_bg, xCoordinate, yCoordinate);
        end
        mx = 5; my = 20;
    endtask

    task automatic test_later_entry();
        write_seg(1, mk_seg(1, 1, 173, 60, 100));
        while (mx < 79) begin
            int n;
            n = (79 - mx > 15) ? 15 : 79 - mx;
            do_move(2'd0, 4'(n), 0, 0);
            mx += n; my += n;
        end
        do_move(2'd2, 4'd1, 0, 0);
        mx = 80; my = 93;
        checks++;
        if ({xCoordinate, yCoordinate} !== {9'(mx), 8'(my)}) begin
            errors++;
            $display("FAIL walk_pos: got (%0d,%0d), expected (%0d,%0d)", xCoordinate, yCoordinate, mx, my);
        end
        write_seg(0, mk_seg(0, 0, 15, 1, 161));
        write_seg(1, mk_seg(0, 1, 173, 60, 100));
        write_seg(2, mk_seg(1, 1, 173, 60, 100));
        do_move(2'd1, 4'd1, 0, 0);
        checks++;
        if (bg_cyc !== 5) begin
            errors++;
            $display("FAIL entry2_drawbg: cycle %0d, expected 5", bg_cyc);
        end
        checks++;
        if ({xCoordinate, yCoordinate} !== {9'd79, 8'd94}) begin
            errors++;
            $display("FAIL entry2_pos: got (%0d,%0d), expected (79,94)", xCoordinate, yCoordinate);
        end
        write_seg(2, mk_seg(1, 1, 173, 60, 79));
        do_move(2'd2, 4'd1, 0, 0);
        checks++;
        if (blk_cyc !== 6 || n_bg !== 0 || {xCoordinate, yCoordinate} !== {9'd79, 8'd94}) begin
            errors++;
            $display("FAIL xmax_edge: blocked cycle %0d drawBG %0d pos (%0d,%0d), expected 6,0,(79,94)",
                     blk_cyc, n_bg, xCoordinate, yCoordinate);
        end
    endtask

    task automatic test_reset_mid_move();
        int cyc;
        @(negedge clock);
        dir = 2'd1; steps = 4'd1; move = 1'b1;
        @(negedge clock);
        move = 1'b0;
        cyc = 1;
        while (!drawBG && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        checks++;
        if (drawBG !== 1'b1) begin
            errors++;
            $display("FAIL midreset_setup: drawBG never seen within %0d cycles, expected 1", cyc);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if ({xCoordinate, yCoordinate} !== {9'd1, 8'd16}) begin
            errors++;
            $display("FAIL midreset_pos: got (%0d,%0d), expected (1,16)", xCoordinate, yCoordinate);
        end
        checks++;
        if ({drawBG, drawChar, busy, blocked} !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_outputs: got %b, expected 0000", {drawBG, drawChar, busy, blocked});
        end
        do_move(2'd0, 4'd1, 0, 0);
        checks++;
        if (blk_cyc !== 6 || n_bg !== 0) begin
            errors++;
            $display("FAIL midreset_table: blocked cycle %0d drawBG %0d, expected 6 and 0", blk_cyc, n_bg);
        end
    endtask

    task automatic test_protocol();
        write_seg(0, mk_seg(1, 0, 15, 1, 161));
        do_move(2'd0, 4'd1, 0, 1);
        checks++;
        if (n_bg !== 1 || {xCoordinate, yCoordinate} !== {9'd2, 8'd17}) begin
            errors++;
            $display("FAIL busy_move_ignored: drawBG %0d pos (%0d,%0d), expected 1 and (2,17)", n_bg, xCoordinate, yCoordinate);
        end
        do_move(2'd0, 4'd1, 0, 0);
        checks++;
        if (n_bg !== 1 || n_blk !== 0 || {xCoordinate, yCoordinate} !== {9'd3, 8'd18}) begin
            errors++;
            $display("FAIL busy_write_ignored: drawBG %0d blocked %0d pos (%0d,%0d), expected 1,0,(3,18)",
                     n_bg, n_blk, xCoordinate, yCoordinate);
        end
        do_move(2'd0, 4'd1, 1, 0);
        checks++;
        if (bg_cyc !== 3 || ch_cyc !== 6) begin
            errors++;
            $display("FAIL early_done: drawBG cycle %0d drawChar cycle %0d, expected 3 and 6", bg_cyc, ch_cyc);
        end
        checks++;
        if (n_char !== 1 || end_cyc !== 8 || {xCoordinate, yCoordinate} !== {9'd4, 8'd19}) begin
            errors++;
            $display("FAIL early_done_final: drawChar %0d idle cycle %0d pos (%0d,%0d), expected 1,8,(4,19)",
                     n_char, end_cyc, xCoordinate, yCoordinate);
        end
    endtask

    initial begin
        reset = 1'b1; move = 1'b0; dir = 2'd0; steps = 4'd0;
        seg_we = 1'b0; seg_idx = 2'd0; seg_data = '0;
        doneBG = 1'b0; doneChar = 1'b0;
        test_reset();
        test_single_step();
        test_underflow();
        test_multi_step();
        test_later_entry();
        test_reset_mid_move();
        test_protocol();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
